// File: rtl/sop_decoder_pipe.sv
// Two-stage pipelined one-hot decoder with a serially loaded truth table.
// It also keeps a saturating count of decoded items whose truth-table entry is 1.
module sop_decoder_pipe #(
  parameter int IN_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   tt_load,
  input  logic                   tt_bit,
  input  logic                   cnt_clr,
  output logic                   out_valid,
  output logic [(1<<IN_W)-1:0]   out_onehot,
  output logic                   out_func,
  output logic [CNT_W-1:0]       hit_count,
  output logic                   tt_ready
);

  localparam int DEPTH = 1 << IN_W;
  localparam int LC_W  = IN_W + 1;

  logic [DEPTH-1:0] r_tt;
  logic [LC_W-1:0]  r_ld_cnt;
  logic             r_s1_valid;
  logic [IN_W-1:0]  r_s1_data;
  logic             r_s2_valid;
  logic             r_s2_func;
  logic [DEPTH-1:0] r_s2_onehot;
  logic [CNT_W-1:0] r_hit_cnt;

  logic             w_accept;
  logic             w_func;
  logic [DEPTH-1:0] w_onehot;
  logic             w_cnt_max;

  // A load strobe steals the cycle: a coincident input item is dropped.
  assign w_accept  = in_valid & ~tt_load;
  assign w_func    = r_s1_valid & r_tt[r_s1_data];
  assign w_onehot  = r_s1_valid ? (DEPTH'(1) << r_s1_data) : '0;
  assign w_cnt_max = (r_hit_cnt == {CNT_W{1'b1}});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; stage 2 therefore reads the TT before a shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tt     <= '0;
      r_ld_cnt <= '0;
    end else if (tt_load) begin
      r_tt <= {r_tt[DEPTH-2:0], tt_bit};
      if (r_ld_cnt != LC_W'(DEPTH)) r_ld_cnt <= r_ld_cnt + LC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_func   <= 1'b0;
      r_s2_onehot <= '0;
    end else begin
      r_s1_valid  <= w_accept;
      r_s1_data   <= in_data;
      r_s2_valid  <= r_s1_valid;
      r_s2_func   <= w_func;
      r_s2_onehot <= w_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt <= '0;
    end else if (w_func && !w_cnt_max) begin
      r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_onehot = r_s2_onehot;
  assign out_func   = r_s2_func;
  assign hit_count  = r_hit_cnt;
  assign tt_ready   = (r_ld_cnt == LC_W'(DEPTH));

endmodule

// File: doc/sop_decoder_pipe.md
Name: sop_decoder_pipe

Overview:
- Parametrised, pipelined 2^IN_W-output one-hot decoder with a run-time programmable sum-of-products function output.
- The fixed-function gate-level combinational circuit becomes a clocked block whose minterm set is a loadable truth-table register.
- Counts how many valid inputs hit the programmed function.
- Used as a reusable test circuit for timing and sequential-logic regressions in the project's circuit suite.

Parameters:
- IN_W, 4, number of select inputs; decoder width and truth-table depth are 2^IN_W.
- CNT_W, 8, width of the saturating hit counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid this cycle
- in_data  input  IN_W  select vector; MSB is the most-significant literal
- tt_load  input  1  shift-load strobe for the truth table
- tt_bit  input  1  serial truth-table bit, sampled when tt_load=1
- cnt_clr  input  1  synchronous clear of hit_count
- out_valid  output  1  out_onehot and out_func are valid
- out_onehot  output  2^IN_W  one-hot decode of the registered in_data
- out_func  output  1  TT[in_data] for the same item
- hit_count  output  CNT_W  saturating count of items with out_func=1
- tt_ready  output  1  1 when 2^IN_W bits have been loaded since the last reset

Behaviour:
- Reset (rst_n=0, asynchronous):
  - TT=0, load counter=0, tt_ready=0.
  - Both pipeline stages invalid.
  - out_valid=0, out_onehot=0, out_func=0, hit_count=0.
  - Any in-flight item is discarded.
- Truth-table load:
  - Each cycle with tt_load=1: TT <= {TT[2^IN_W-2:0], tt_bit}, so the first bit shifted in ends in the MSB (minterm 2^IN_W-1).
  - Load counter increments and saturates at 2^IN_W; tt_ready=1 once it reaches 2^IN_W.
  - Loading further bits keeps shifting; tt_ready stays 1.
- Input acceptance:
  - An item is accepted when in_valid=1 and tt_load=0.
  - An item with in_valid=1 and tt_load=1 in the same cycle is dropped.
  - No backpressure; one item per cycle sustained.
- Pipeline, latency 2 cycles (accepted at edge N, visible after edge N+2):
  - Stage 1 registers in_data and valid.
  - Stage 2 registers out_onehot (bit in_data set, all others 0), out_func=TT[stage1 data] and out_valid.
  - TT is read at stage-2 evaluation, so a shift in that same cycle is not yet seen; the pre-edge TT value is used.
- Output hold and bubbles:
  - With out_valid=0, out_onehot=0 and out_func=0.
  - Bubbles propagate; no stale data is shown.
- hit_count:
  - Increments on each edge where the stage-2 result being registered has valid=1 and func=1.
  - Saturates at 2^CNT_W-1, with no wrap.
  - cnt_clr=1 forces 0 and has priority over an increment in the same cycle.
- Items may be accepted before tt_ready=1; they evaluate against the partial TT without error.
- Any integer IN_W >= 1 is supported; IN_W=1 gives a 2-bit one-hot output.

Test Plan:
- Reset, then shift 16 bits of 16'h5144 MSB-first -> tt_ready=1 after the 16th strobe; TT=16'h5144.
- Sweep in_data 0..15 back-to-back with in_valid=1 -> out_valid=1 on cycles 2..17; out_onehot=1<<k; out_func=1 only for k in {2,6,8,12,14}; hit_count ends at 5.
- in_valid=1 with tt_load=1 in the same cycle, in_data=4'd6 -> no output item 2 cycles later; TT shifts once.
- CNT_W=3: feed 10 items of in_data=4'd2 -> hit_count saturates at 7. cnt_clr coinciding with a hit -> hit_count=0.
- Assert rst_n=0 asynchronously mid-sweep, one cycle after an item is accepted -> outputs 0 immediately without a clock edge; no out_valid after release; tt_ready=0.
- Alternate in_valid 1/0 with in_data=4'd8 -> out_valid toggles with 2-cycle lag; out_onehot=16'h0100 on valid cycles and 0 on bubbles.
